// File: rtl/dma_desc_fetch.sv
// dma_desc_fetch -- scatter-gather descriptor fetcher (AVMM read master).
//
// When RUN rises, the block walks a contiguous descriptor array. Descriptor
// idx lives at csr_first_pointer_i + (idx << DESC_STRIDE_LOG2). Each descriptor
// is read as one BURST_LEN-beat burst. Word3[31] is the hardware-ownership bit.
// Descriptors owned by hardware are presented to the engines on a valid/ready
// port. The walk stops after a descriptor flagged last, at the first descriptor
// not owned by hardware, or when RUN is cleared.
//
// Optional feature: define DMA_DESC_FETCH_TIMEOUT_EN to enable a per-descriptor
// fetch watchdog. The watchdog sets fetch_err_o and ends the walk. Without the
// macro, fetch_err_o is constant 0.
//
// Ports:
//   clk, reset                    clock; synchronous active-high reset
//   csr_control_i[0]              RUN (other bits ignored)
//   csr_first_pointer_i           byte address of descriptor 0
//   fetch_busy_o                  high outside IDLE/DONE
//   fetch_done_o                  one-cycle pulse on entry to DONE
//   fetch_err_o                   sticky watchdog error, cleared on start
//   dma_desc_fetch_*              AVMM read master (rd/addr/burstcount,
//                                 waitrequest, readdata, readdatavalid)
//   desc_valid_o / desc_ready_i   descriptor handshake to the engines
//   desc_rd_addr_o, desc_wr_addr_o, desc_len_o, desc_idx_o, desc_last_o
//                                 descriptor fields, stable while valid
module dma_desc_fetch #(
   parameter int unsigned DESC_STRIDE_LOG2 = 5,
   parameter int unsigned BURST_LEN        = 4,
   parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] csr_control_i,
   input  logic [31:0] csr_first_pointer_i,
   output logic        fetch_busy_o,
   output logic        fetch_done_o,
   output logic        fetch_err_o,
   output logic        dma_desc_fetch_rd_o,
   output logic [31:0] dma_desc_fetch_addr_o,
   output logic [2:0]  dma_desc_fetch_burstcount_o,
   input  logic        dma_desc_fetch_wait_req_i,
   input  logic [31:0] dma_desc_fetch_rdata_i,
   input  logic        dma_desc_fetch_rdata_valid_i,
   output logic        desc_valid_o,
   input  logic        desc_ready_i,
   output logic [31:0] desc_rd_addr_o,
   output logic [31:0] desc_wr_addr_o,
   output logic [15:0] desc_len_o,
   output logic [7:0]  desc_idx_o,
   output logic        desc_last_o
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_DATA = 3'd2,
      ST_CHECK     = 3'd3,
      ST_PRESENT   = 3'd4,
      ST_DONE      = 3'd5
   } state_e;

   localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);

   state_e      state_q, state_d;
   logic [7:0]  idx_q, idx_d;
   logic [1:0]  beat_q, beat_d;
   logic [31:0] word_q [4];
   logic [31:0] word_d [4];
   logic        stop_q, stop_d;
   logic        err_q, err_d;
   logic        done_q;
   logic        run_prev_q;

   logic        run;
   logic        start;
   logic        tmo_hit;

   assign run   = csr_control_i[0];
   assign start = run & ~run_prev_q;

`ifdef DMA_DESC_FETCH_TIMEOUT_EN
   logic [10:0] tmo_q, tmo_d;

   // The counter restarts for every descriptor and saturates once it has
   // fired, so the error cannot re-trigger while the burst drains.
   always_comb begin
      tmo_d = tmo_q;
      if (state_d == ST_ISSUE && state_q != ST_ISSUE) begin
         tmo_d = '0;
      end else if ((state_q == ST_ISSUE || state_q == ST_WAIT_DATA) &&
                   tmo_q != 11'(TIMEOUT_CYCLES)) begin
         tmo_d = tmo_q + 11'd1;
      end
   end

   assign tmo_hit = (state_q == ST_ISSUE || state_q == ST_WAIT_DATA) &&
                    (tmo_q == 11'(TIMEOUT_CYCLES));

   always_ff @(posedge clk) begin
      if (reset) tmo_q <= '0;
      else       tmo_q <= tmo_d;
   end
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT_CYCLES == 0);
   assign tmo_hit    = 1'b0;
`endif

   // Next-state logic. stop_q records that the walk must end once the
   // burst in flight has drained, or once the pending handshake completes.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      beat_d  = beat_q;
      word_d  = word_q;
      stop_d  = stop_q;
      err_d   = err_q | tmo_hit;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               idx_d   = '0;
               err_d   = 1'b0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // An accepted command always gets its burst drained, even when
            // the walk is ending in the same cycle.
            if (!dma_desc_fetch_wait_req_i) begin
               beat_d  = '0;
               stop_d  = !run || tmo_hit;
               state_d = ST_WAIT_DATA;
            end else if (!run || tmo_hit) begin
               state_d = ST_DONE;
            end
         end
         ST_WAIT_DATA: begin
            if (!run || tmo_hit) stop_d = 1'b1;
            if (dma_desc_fetch_rdata_valid_i) begin
               word_d[beat_q] = dma_desc_fetch_rdata_i;
               beat_d         = beat_q + 2'd1;
               if (beat_q == LAST_BEAT) begin
                  state_d = (stop_q || !run || tmo_hit) ? ST_DONE : ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            state_d = (run && word_q[3][31]) ? ST_PRESENT : ST_DONE;
         end
         ST_PRESENT: begin
            if (!run) stop_d = 1'b1;
            if (desc_ready_i) begin
               if (word_q[3][0] || stop_q || !run) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + 8'd1;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_DONE: begin
            if (!run) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         beat_q     <= '0;
         word_q     <= '{default: '0};
         stop_q     <= 1'b0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         run_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         beat_q     <= beat_d;
         word_q     <= word_d;
         stop_q     <= stop_d;
         err_q      <= err_d;
         done_q     <= (state_d == ST_DONE) && (state_q != ST_DONE);
         run_prev_q <= run;
      end
   end

   assign fetch_busy_o = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign fetch_done_o = done_q;
   assign fetch_err_o  = err_q;

   assign dma_desc_fetch_rd_o         = (state_q == ST_ISSUE);
   assign dma_desc_fetch_addr_o       = dma_desc_fetch_rd_o ?
      csr_first_pointer_i + ({24'b0, idx_q} << DESC_STRIDE_LOG2) : '0;
   assign dma_desc_fetch_burstcount_o = 3'(BURST_LEN);

   assign desc_valid_o   = (state_q == ST_PRESENT);
   assign desc_rd_addr_o = word_q[0];
   assign desc_wr_addr_o = word_q[1];
   assign desc_len_o     = word_q[2][15:0];
   assign desc_idx_o     = idx_q;
   assign desc_last_o    = word_q[3][0];

   logic unused_bits;
   assign unused_bits = ^{csr_control_i[31:1], word_q[2][31:16], word_q[3][30:1]};

endmodule

// File: tb/tb_dma_desc_fetch.sv
module tb_dma_desc_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] csr_control;
   logic [31:0] first_ptr;
   logic        busy, done, err;
   logic        dma_rd;
   logic [31:0] dma_addr;
   logic [2:0]  dma_burst;
   logic        wait_req;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        desc_valid;
   logic        desc_ready;
   logic [31:0] d_rd_addr, d_wr_addr;
   logic [15:0] d_len;
   logic [7:0]  d_idx;
   logic        d_last;

   always #5 clk = ~clk;

   dma_desc_fetch #(.DESC_STRIDE_LOG2(5), .BURST_LEN(4), .TIMEOUT_CYCLES(1024)) dut (
      .clk                          (clk),
      .reset                        (reset),
      .csr_control_i                (csr_control),
      .csr_first_pointer_i          (first_ptr),
      .fetch_busy_o                 (busy),
      .fetch_done_o                 (done),
      .fetch_err_o                  (err),
      .dma_desc_fetch_rd_o          (dma_rd),
      .dma_desc_fetch_addr_o        (dma_addr),
      .dma_desc_fetch_burstcount_o  (dma_burst),
      .dma_desc_fetch_wait_req_i    (wait_req),
      .dma_desc_fetch_rdata_i       (rdata),
      .dma_desc_fetch_rdata_valid_i (rdata_valid),
      .desc_valid_o                 (desc_valid),
      .desc_ready_i                 (desc_ready),
      .desc_rd_addr_o               (d_rd_addr),
      .desc_wr_addr_o               (d_wr_addr),
      .desc_len_o                   (d_len),
      .desc_idx_o                   (d_idx),
      .desc_last_o                  (d_last)
   );

   int n_total = 0;
   int n_pass  = 0;

   // Memory image and observation/expectation queues.
   logic [31:0]  mem [bit [31:0]];
   logic [31:0]  beats [$];
   bit   [31:0]  acc_a [$];
   bit   [31:0]  exp_a [$];
   logic [127:0] got   [$];
   logic [127:0] exp_d [$];

   int cyc, done_cnt, burst_beats, last_beat_cyc, rd_hi_cnt, first_acc_rdhi;
   int force_wait, ready_low, stall_pending, drop_beat, drop_present;
   bit rand_wait, rand_gap, rand_ready, hold_data, spurious;
   bit cmd_pend, hold_pend, prev_valid;
   logic [31:0]  cmd_snap;
   logic [127:0] hold_snap;
   bit   [31:0]  first;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] rdmem(input bit [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h0;
   endfunction

   function automatic logic [127:0] desc_now();
      return {39'b0, d_idx, d_rd_addr, d_wr_addr, d_len, d_last};
   endfunction

   task automatic set_run(input bit b);
      logic [31:0] t;
      t = $urandom;
      t[0] = b;
      csr_control = t;
   endtask

   task automatic set_desc(input bit [31:0] base, input int idx, input bit owned, input bit last);
      bit [31:0]   a;
      logic [31:0] w3;
      a = base + 32'(idx * 32);
      mem[a]      = $urandom;
      mem[a + 4]  = $urandom;
      mem[a + 8]  = $urandom;
      w3          = $urandom;
      w3[31]      = owned;
      w3[0]       = last;
      mem[a + 12] = w3;
   endtask

   // Reference walk: follow the descriptor array from idx 0 until a
   // descriptor is not owned, a last descriptor is seen, or max_n reads.
   task automatic walk(input bit [31:0] base, input int max_n);
      int          idx;
      bit   [31:0] a;
      logic [31:0] w2, w3;
      exp_a.delete();
      exp_d.delete();
      idx = 0;
      for (int n = 0; n < max_n; n++) begin
         a = base + 32'(idx * 32);
         exp_a.push_back(a);
         w2 = rdmem(a + 8);
         w3 = rdmem(a + 12);
         if (!w3[31]) break;
         exp_d.push_back({39'b0, 8'(idx), rdmem(a), rdmem(a + 4), w2[15:0], w3[0]});
         if (w3[0]) break;
         idx = (idx + 1) % 256;
      end
   endtask

   task automatic clear_obs();
      acc_a.delete();
      got.delete();
      done_cnt    = 0;
      rd_hi_cnt   = 0;
      first_acc_rdhi = 0;
   endtask

   task automatic new_test();
      clear_obs();
      mem.delete();
      force_wait = 0; ready_low = 0; stall_pending = 0;
      drop_beat = -1; drop_present = -1;
      rand_wait = 0; rand_gap = 0; rand_ready = 0; hold_data = 0;
   endtask

   // One bench cycle at the falling edge: check held outputs, then act as the
   // AVMM slave and the descriptor consumer for the next rising edge.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
      if (cmd_pend) begin
         chk("cmd_hold_rd", dma_rd, 1);
         chk("cmd_hold_addr", dma_addr, cmd_snap);
      end
      if (hold_pend) begin
         chk("desc_hold_valid", desc_valid, 1);
         chk("desc_hold_fields", desc_now(), hold_snap);
      end
      if (desc_valid && !prev_valid) chk("valid_latency", 128'(cyc - last_beat_cyc), 128'd2);
      if (desc_valid) chk("no_rd_in_present", dma_rd, 0);
      prev_valid = desc_valid;

      // read data return
      if (beats.size() > 0 && !hold_data && (!rand_gap || $urandom_range(0, 2) != 0)) begin
         rdata_valid = 1'b1;
         rdata = beats.pop_front();
         burst_beats++;
         if (burst_beats == drop_beat + 1) begin
            set_run(1'b0);
            drop_beat = -1;
         end
         if (burst_beats == 4) begin
            burst_beats = 0;
            last_beat_cyc = cyc;
         end
      end else if (spurious) begin
         rdata_valid = 1'b1;
         rdata = 32'hDEADBEEF;
         spurious = 0;
      end else begin
         rdata_valid = 1'b0;
         rdata = $urandom;
      end

      // command acceptance
      if (dma_rd) begin
         rd_hi_cnt++;
         if (force_wait > 0) begin
            wait_req = 1'b1;
            force_wait--;
         end else begin
            wait_req = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
         end
         if (!wait_req) begin
            acc_a.push_back(dma_addr);
            chk("burstcount", dma_burst, 4);
            if (acc_a.size() == 1) first_acc_rdhi = rd_hi_cnt;
            for (int b = 0; b < 4; b++) beats.push_back(rdmem(dma_addr + 32'(b * 4)));
         end
         cmd_pend = wait_req;
         cmd_snap = dma_addr;
      end else begin
         wait_req = 1'($urandom_range(0, 1));
         cmd_pend = 0;
      end

      // descriptor consumer
      if (desc_valid && stall_pending > 0) begin
         ready_low = stall_pending;
         stall_pending = 0;
      end
      if (drop_present >= 0 && desc_valid && got.size() == drop_present) begin
         set_run(1'b0);
         drop_present = -1;
      end
      if (ready_low > 0) begin
         desc_ready = 1'b0;
         if (desc_valid) ready_low--;
      end else begin
         desc_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (desc_valid && desc_ready) begin
         got.push_back(desc_now());
         hold_pend = 0;
      end else begin
         hold_pend = desc_valid;
         hold_snap = desc_now();
      end
   endtask

   task automatic wait_done(input int budget);
      int start_cnt;
      int n;
      start_cnt = done_cnt;
      n = 0;
      while (done_cnt == start_cnt && n < budget) begin
         tick();
         n++;
      end
      chk("done_reached", done_cnt != start_cnt, 1);
   endtask

   task automatic check_chain();
      chk("n_reads", acc_a.size(), exp_a.size());
      chk("n_desc", got.size(), exp_d.size());
      for (int i = 0; i < acc_a.size() && i < exp_a.size(); i++) chk("read_addr", acc_a[i], exp_a[i]);
      for (int i = 0; i < got.size() && i < exp_d.size(); i++) chk("desc_fields", got[i], exp_d[i]);
   endtask

   task automatic go_idle();
      set_run(1'b0);
      repeat (4) tick();
      chk("idle_busy", busy, 0);
   endtask

   task automatic three_chain(input bit [31:0] base);
      set_desc(base, 0, 1, 0);
      set_desc(base, 1, 1, 0);
      set_desc(base, 2, 1, 1);
   endtask

   initial begin
      cyc = 0; burst_beats = 0; last_beat_cyc = 0;
      spurious = 0; cmd_pend = 0; hold_pend = 0; prev_valid = 0;
      reset = 1'b1; csr_control = '0; first_ptr = '0;
      wait_req = 1'b0; rdata = '0; rdata_valid = 1'b0; desc_ready = 1'b0;
      new_test();
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rd", dma_rd, 0);
      chk("rst_addr", dma_addr, 0);
      chk("rst_burst", dma_burst, 4);
      chk("rst_valid", desc_valid, 0);
      chk("rst_fields", desc_now(), 0);
      reset = 1'b0;
      set_run(1'b0);
      repeat (2) tick();

      // readdatavalid while idle must not load the descriptor registers
      spurious = 1;
      repeat (2) tick();
      chk("spurious_ignored", d_rd_addr, 0);

      // basic three-descriptor chain
      new_test();
      first = 32'h1000; first_ptr = first;
      three_chain(first);
      walk(first, 300);
      set_run(1'b1);
      tick();
      chk("issue_latency_rd", dma_rd, 1);
      chk("issue_addr0", dma_addr, 32'h1000);
      wait_done(500);
      repeat (12) tick();
      chk("done_once", done_cnt, 1);
      chk("busy_in_done", busy, 0);
      chk("no_retrigger", acc_a.size(), 3);
      check_chain();
      go_idle();

      // waitrequest held on the first command
      new_test();
      three_chain(first);
      walk(first, 300);
      force_wait = 5;
      set_run(1'b1);
      wait_done(500);
      chk("wait_rd_cycles", first_acc_rdhi, 6);
      check_chain();
      go_idle();

      // descriptor 1 not owned by hardware
      new_test();
      set_desc(first, 0, 1, 0);
      set_desc(first, 1, 0, 0);
      set_desc(first, 2, 1, 1);
      walk(first, 300);
      set_run(1'b1);
      wait_done(500);
      check_chain();
      go_idle();

      // consumer stalls 10 cycles on the first descriptor
      new_test();
      three_chain(first);
      walk(first, 300);
      stall_pending = 10;
      set_run(1'b1);
      wait_done(500);
      check_chain();
      go_idle();

      // RUN dropped after beat 1: burst drains, nothing presented; then restart
      new_test();
      three_chain(first);
      drop_beat = 1;
      exp_a.delete(); exp_a.push_back(first);
      exp_d.delete();
      set_run(1'b1);
      wait_done(500);
      check_chain();
      go_idle();
      clear_obs();
      walk(first, 300);
      set_run(1'b1);
      wait_done(500);
      check_chain();
      go_idle();

      // 256 non-last descriptors near the top of the address space
      new_test();
      first = 32'hFFFF_F000; first_ptr = first;
      for (int i = 0; i < 256; i++) set_desc(first, i, 1, 0);
      walk(first, 257);
      rand_wait = 1; rand_gap = 1; rand_ready = 1;
      drop_present = 256;
      set_run(1'b1);
      wait_done(30000);
      check_chain();
      go_idle();

`ifdef DMA_DESC_FETCH_TIMEOUT_EN
      // read data withheld: watchdog fires, burst still drained
      new_test();
      first = 32'h1000; first_ptr = first;
      three_chain(first);
      hold_data = 1;
      set_run(1'b1);
      repeat (1000) tick();
      chk("tmo_err_early", err, 0);
      chk("tmo_not_done", done_cnt, 0);
      repeat (60) tick();
      chk("tmo_err_set", err, 1);
      hold_data = 0;
      exp_a.delete(); exp_a.push_back(first);
      exp_d.delete();
      wait_done(100);
      check_chain();
      chk("tmo_err_sticky", err, 1);
      go_idle();
      clear_obs();
      walk(first, 300);
      set_run(1'b1);
      tick();
      chk("tmo_err_cleared", err, 0);
      wait_done(500);
      check_chain();
      go_idle();
`else
      chk("err_tied_low", err, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dma_desc_fetch.md
Name: dma_desc_fetch

Overview:
- Scatter-gather descriptor fetcher: the AVMM read-side counterpart of the descriptor status-update writer.
- On software start it walks a contiguous descriptor array beginning at csr_first_pointer_i, with a 32-byte stride indexed by an 8-bit descriptor index.
- Each descriptor is read as a 4-beat burst, checked for hardware ownership, and presented to the read/write engines on a valid/ready port, together with the index and last flag those engines return through the status path.

Parameters:
- DESC_STRIDE_LOG2, 5, log2 of descriptor stride in bytes (address = first_ptr + idx<<5).
- BURST_LEN, 4, 32-bit words read per descriptor.
- TIMEOUT_CYCLES, 1024, watchdog limit per descriptor fetch (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- csr_control_i  in  32  bit0 = RUN; other bits ignored.
- csr_first_pointer_i  in  32  byte address of descriptor 0.
- fetch_busy_o  out  1  high in any state except IDLE/DONE.
- fetch_done_o  out  1  one-cycle pulse on entry to DONE.
- fetch_err_o  out  1  sticky timeout error, cleared on start.
- dma_desc_fetch_rd_o  out  1  AVMM read request.
- dma_desc_fetch_addr_o  out  32  AVMM read address.
- dma_desc_fetch_burstcount_o  out  3  constant BURST_LEN.
- dma_desc_fetch_wait_req_i  in  1  AVMM waitrequest.
- dma_desc_fetch_rdata_i  in  32  AVMM readdata.
- dma_desc_fetch_rdata_valid_i  in  1  AVMM readdatavalid.
- desc_valid_o  out  1  descriptor available to the engines.
- desc_ready_i  in  1  engine accepts descriptor.
- desc_rd_addr_o  out  32  word0: source address.
- desc_wr_addr_o  out  32  word1: destination address.
- desc_len_o  out  16  word2[15:0]: byte count.
- desc_idx_o  out  8  descriptor index.
- desc_last_o  out  1  word3[0]: last descriptor in chain.

Behaviour:
- Reset: state IDLE; idx=0; every output 0 except dma_desc_fetch_burstcount_o = BURST_LEN. Descriptor registers cleared.
- Start: detect a RUN rising edge (registered previous RUN). In IDLE, this clears idx and fetch_err_o and moves to ISSUE. RUN held high does not retrigger.
- ISSUE:
  - rd_o=1; addr_o = csr_first_pointer_i + ({24'b0,idx}<<DESC_STRIDE_LOG2), computed in 32-bit arithmetic with wrap-around.
  - rd_o, addr and burstcount are held stable while wait_req_i=1.
  - Command is accepted in the cycle rd_o=1 and wait_req_i=0; next state is WAIT_DATA and rd_o drops the following cycle.
- WAIT_DATA:
  - 2-bit beat counter; each rdata_valid_i captures rdata into word[beat].
  - After beat 3, go to CHECK.
  - rdata_valid_i outside WAIT_DATA is ignored.
- CHECK (1 cycle): word3[31] = OWNED_BY_HW. If 0, go to DONE and present nothing. If 1, go to PRESENT.
- PRESENT:
  - desc_valid_o=1; all desc_* outputs are stable until the handshake (valid & ready).
  - On handshake: if last, go to DONE; otherwise idx increments and the block goes to ISSUE.
  - idx 255 with a non-last descriptor wraps to 0 and continues.
- DONE: fetch_done_o pulses on entry; the block stays in DONE until RUN=0, then goes to IDLE.
- RUN deasserted mid-chain:
  - In ISSUE before acceptance: go to DONE immediately.
  - In WAIT_DATA: all remaining beats are drained, then DONE (never abandon a burst).
  - In CHECK: go to DONE.
  - In PRESENT: valid is never withdrawn; the block waits for the handshake, then goes to DONE.
- Latency: command issue occurs 1 cycle after start; desc_valid_o rises 2 cycles after the 4th beat.
- States are encoded in 3 bits; illegal encodings go to IDLE.

Optional Feature:
- DMA_DESC_FETCH_TIMEOUT_EN defined:
  - An 11-bit counter clears on entry to ISSUE and increments in ISSUE/WAIT_DATA.
  - On reaching TIMEOUT_CYCLES, fetch_err_o is set.
  - If no command is outstanding (still in ISSUE), go to DONE immediately.
  - If a command is outstanding (WAIT_DATA), go to DONE after the remaining beats arrive.
- Undefined: no counter; fetch_err_o is tied 0.

Test Plan:
- first_ptr=0x1000, 3 descriptors, owned=1, last on idx2, ready always 1 -> reads at 0x1000/0x1020/0x1040 with burstcount 4; desc_idx 0,1,2; desc_last only on idx2; fetch_done_o pulses once.
- wait_req_i held 5 cycles on the first command -> rd_o and addr stay 0x1000 for 6 cycles; exactly one command is accepted.
- Descriptor 1 has word3[31]=0 -> only idx0 is presented; DONE is reached with no read at 0x1040.
- desc_ready_i low for 10 cycles in PRESENT -> desc_valid_o and all fields hold constant; no new read is issued until the handshake.
- RUN cleared after beat 1 -> beats 2–3 are consumed, no descriptor is presented, DONE; RUN rise after returning to IDLE restarts at idx0.
- 256 non-last owned descriptors with first_ptr=0xFFFF_F000 -> idx wraps 255->0; address wraps modulo 2^32 to 0xFFFF_F000; with TIMEOUT_EN, withholding rdata_valid_i for 1024 cycles sets fetch_err_o=1.
